// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage indices, PC-select codes, FSM states.
package ysyx_041461_pipe_ctrl_pkg;

    localparam int unsigned NUM_STAGES = 6;
    localparam int unsigned STAGE_IF   = 0;
    localparam int unsigned STAGE_IF2  = 1;
    localparam int unsigned STAGE_ID   = 2;
    localparam int unsigned STAGE_EXE  = 3;
    localparam int unsigned STAGE_MEM  = 4;
    localparam int unsigned STAGE_WB   = 5;

    localparam logic [1:0] PC_SEL_SNPC = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP = 2'b01;
    localparam logic [1:0] PC_SEL_TRAP = 2'b10;

    // Cause encoding that never accompanies a valid trap.
    localparam logic [3:0] TRAP_NOP = 4'hF;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StFlush  = 2'd1,
        StRefill = 2'd2
    } pipe_state_e;

    // Bits 0..s set: every stage at or upstream of s holds.
    function automatic logic [NUM_STAGES-1:0] upstream_mask(input logic [2:0] s);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            m[k] = (3'(k) <= s);
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_041461_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module ysyx_041461_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = &cnt_q;
    assign q      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline sequencer: hazard/busy/jump flags to per-stage stall/flush and PC-select,
// plus trap entry sequencing (RUN -> FLUSH -> REFILL) and stall/hang accounting.
module ysyx_041461_pipe_ctrl
    import ysyx_041461_pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned HANG_W     = 16,
    parameter int unsigned HANG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cd_id_conflict,
    input  logic             cd_exe_conflict,
    input  logic             cd_mem_conflict,
    input  logic [4:0]       cd_kill,
    input  logic             ifu_busy,
    input  logic             lsu_busy,
    input  logic             id_jump,
    input  logic             wb_trap_valid,
    input  logic [3:0]       wb_trap_code,
    output logic [5:0]       stage_stall,
    output logic [5:0]       stage_flush,
    output logic [1:0]       pc_sel,
    output logic             csr_trap_en,
    output logic [3:0]       csr_trap_code,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             hang
);

    pipe_state_e state_q, state_d;
    logic [3:0]  trap_code_q, trap_code_d;
    logic        hang_q, hang_d;

    logic        src_vld;
    logic [2:0]  src;
    logic [5:0]  run_stall, run_flush;
    logic [1:0]  run_pc_sel;
    logic        stalled_run;
    logic [HANG_W-1:0] consec_q;
    logic        unused_stall_at_max, unused_consec_at_max;

    // Most-downstream stall source decides how far the hold reaches.
    always_comb begin
        src_vld = 1'b1;
        src     = 3'd0;
        if (lsu_busy || cd_mem_conflict) begin
            src = 3'd4;
        end else if (cd_exe_conflict) begin
            src = 3'd3;
        end else if (cd_id_conflict) begin
            src = 3'd2;
        end else if (ifu_busy) begin
            src = 3'd0;
        end else begin
            src_vld = 1'b0;
        end
    end

    always_comb begin
        run_stall  = src_vld ? upstream_mask(src) : 6'b0;
        run_flush  = src_vld ? (6'b1 << (src + 3'd1)) : 6'b0;
        run_flush  = run_flush | {1'b0, cd_kill};
        run_pc_sel = PC_SEL_SNPC;
        if (id_jump && !run_stall[STAGE_ID] && !cd_kill[STAGE_ID]) begin
            run_pc_sel          = PC_SEL_JUMP;
            run_flush[STAGE_IF]  = 1'b1;
            run_flush[STAGE_IF2] = 1'b1;
        end
        run_stall = run_stall & ~run_flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            trap_code_q <= '0;
            hang_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trap_code_q <= trap_code_d;
            hang_q      <= hang_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trap_code_d = trap_code_q;
        unique case (state_q)
            StRun: begin
                if (wb_trap_valid) begin
                    state_d     = StFlush;
                    trap_code_d = wb_trap_code;
                end
            end
            StFlush, StRefill: state_d = ifu_busy ? StRefill : StRun;
            default:           state_d = StRun;
        endcase
    end

    always_comb begin
        stage_stall = 6'b0;
        stage_flush = 6'b0;
        pc_sel      = PC_SEL_SNPC;
        csr_trap_en = 1'b0;
        unique case (state_q)
            StRun: begin
                if (wb_trap_valid) begin
                    csr_trap_en = 1'b1;
                end else begin
                    stage_stall = run_stall;
                    stage_flush = run_flush;
                    pc_sel      = run_pc_sel;
                end
            end
            StFlush: begin
                stage_flush = 6'h3F;
                pc_sel      = PC_SEL_TRAP;
            end
            StRefill: begin
                stage_flush[STAGE_IF] = 1'b1;
                pc_sel                = PC_SEL_TRAP;
            end
            default: ;
        endcase
    end

    assign stalled_run   = (state_q == StRun) && (|stage_stall);
    assign hang_d        = hang_q | (stalled_run && (consec_q == HANG_W'(HANG_LIMIT - 1)));
    assign hang          = hang_q;
    assign csr_trap_code = trap_code_q;

    ysyx_041461_sat_cnt #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stalled_run),
        .clr   (1'b0),
        .q     (stall_cnt),
        .at_max(unused_stall_at_max)
    );

    ysyx_041461_sat_cnt #(
        .W(HANG_W)
    ) u_consec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stalled_run),
        .clr   (!stalled_run),
        .q     (consec_q),
        .at_max(unused_consec_at_max)
    );

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_ysyx_041461_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cd_id_conflict, cd_exe_conflict, cd_mem_conflict;
    logic [4:0]  cd_kill;
    logic        ifu_busy, lsu_busy, id_jump, wb_trap_valid;
    logic [3:0]  wb_trap_code;
    logic [5:0]  stage_stall, stage_flush;
    logic [1:0]  pc_sel;
    logic        csr_trap_en;
    logic [3:0]  csr_trap_code;
    logic [31:0] stall_cnt;
    logic        hang;

    always #5 clk = ~clk;

    ysyx_041461_pipe_ctrl #(
        .CNT_W     (32),
        .HANG_W    (16),
        .HANG_LIMIT(1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cd_id_conflict (cd_id_conflict),
        .cd_exe_conflict(cd_exe_conflict),
        .cd_mem_conflict(cd_mem_conflict),
        .cd_kill        (cd_kill),
        .ifu_busy       (ifu_busy),
        .lsu_busy       (lsu_busy),
        .id_jump        (id_jump),
        .wb_trap_valid  (wb_trap_valid),
        .wb_trap_code   (wb_trap_code),
        .stage_stall    (stage_stall),
        .stage_flush    (stage_flush),
        .pc_sel         (pc_sel),
        .csr_trap_en    (csr_trap_en),
        .csr_trap_code  (csr_trap_code),
        .stall_cnt      (stall_cnt),
        .hang           (hang)
    );

    typedef struct packed {
        logic       id, exe, mem;
        logic [4:0] kill;
        logic       ifu, lsu, jump, trap;
        logic [3:0] code;
    } in_t;

    typedef struct packed {
        int          tag;
        logic [5:0]  stall, flush;
        logic [1:0]  pc;
        logic        en;
        logic [3:0]  code;
        logic [31:0] cnt;
        logic        hang;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: 0 = running, 1 = flushing, 2 = refilling.
    int          m_mode;
    logic [3:0]  m_code;
    logic [31:0] m_cnt;
    int          m_consec;
    logic        m_hang;

    function automatic void model_reset();
        m_mode = 0; m_code = 4'h0; m_cnt = 32'h0; m_consec = 0; m_hang = 1'b0;
    endfunction

    function automatic exp_t model_out(input in_t i, input int tag);
        exp_t e;
        int   s;
        e = '0;
        e.tag = tag; e.code = m_code; e.cnt = m_cnt; e.hang = m_hang;
        if (m_mode == 1) begin
            e.flush = 6'h3F; e.pc = 2'b10;
        end else if (m_mode == 2) begin
            e.flush = 6'h01; e.pc = 2'b10;
        end else if (i.trap) begin
            e.en = 1'b1;
        end else begin
            s = -1;
            if (i.lsu || i.mem) s = 4;
            else if (i.exe)     s = 3;
            else if (i.id)      s = 2;
            else if (i.ifu)     s = 0;
            if (s >= 0) begin
                for (int k = 0; k <= s; k++) e.stall[k] = 1'b1;
                e.flush[s+1] = 1'b1;
            end
            e.flush = e.flush | {1'b0, i.kill};
            if (i.jump && s < 2 && !i.kill[2]) begin
                e.pc = 2'b01;
                e.flush[1:0] = 2'b11;
            end
            e.stall = e.stall & ~e.flush;
        end
        return e;
    endfunction

    function automatic void model_step(input in_t i, input exp_t e);
        if (m_mode == 0) begin
            if (e.stall != 0) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                m_consec = m_consec + 1;
                if (m_consec >= 1024) m_hang = 1'b1;
            end else begin
                m_consec = 0;
            end
            if (i.trap) begin
                m_code = i.code;
                m_mode = 1;
            end
        end else begin
            m_consec = 0;
            m_mode = i.ifu ? 2 : 0;
        end
    endfunction

    task automatic drive(input in_t i);
        cd_id_conflict = i.id; cd_exe_conflict = i.exe; cd_mem_conflict = i.mem;
        cd_kill = i.kill; ifu_busy = i.ifu; lsu_busy = i.lsu; id_jump = i.jump;
        wb_trap_valid = i.trap; wb_trap_code = i.code;
    endtask

    // Called just after a rising edge; the monitor checks at the following falling edge.
    task automatic step(input in_t i, input int tag);
        exp_t e;
        drive(i);
        e = model_out(i, tag);
        exp_q.push_back(e);
        if (rst_n) model_step(i, e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int tag);
        for (int k = 0; k < n; k++) step('0, tag);
    endtask

    task automatic do_reset(input int tag);
        rst_n = 1'b0;
        model_reset();
        idle(2, tag);
        rst_n = 1'b1;
    endtask

    task automatic check(input int tag, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL t%0d %s: got %0h expected %0h at %0t", tag, name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, "stage_stall", 32'(stage_stall), 32'(e.stall));
            check(e.tag, "stage_flush", 32'(stage_flush), 32'(e.flush));
            check(e.tag, "pc_sel", 32'(pc_sel), 32'(e.pc));
            check(e.tag, "csr_trap_en", 32'(csr_trap_en), 32'(e.en));
            check(e.tag, "csr_trap_code", 32'(csr_trap_code), 32'(e.code));
            check(e.tag, "stall_cnt", stall_cnt, e.cnt);
            check(e.tag, "hang", 32'(hang), 32'(e.hang));
        end
    end

    function automatic in_t rand_in();
        in_t i;
        i = '0;
        i.id   = ($urandom_range(0, 4) == 0);
        i.exe  = ($urandom_range(0, 5) == 0);
        i.mem  = ($urandom_range(0, 7) == 0);
        for (int k = 0; k < 5; k++) i.kill[k] = ($urandom_range(0, 11) == 0);
        i.ifu  = ($urandom_range(0, 2) == 0);
        i.lsu  = ($urandom_range(0, 6) == 0);
        i.jump = ($urandom_range(0, 3) == 0);
        i.trap = ($urandom_range(0, 24) == 0);
        i.code = 4'($urandom_range(0, 14));
        return i;
    endfunction

    in_t ti;

    initial begin
        rst_n = 1'b0;
        drive('0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset(0);
        idle(2, 0);

        // 1: EXE conflict for three cycles
        ti = '0; ti.exe = 1'b1;
        for (int k = 0; k < 3; k++) step(ti, 1);
        idle(1, 1);

        // 2: LSU busy with ID conflict
        ti = '0; ti.lsu = 1'b1; ti.id = 1'b1;
        step(ti, 2);

        // 3: jump taken, then suppressed by an ID stall
        ti = '0; ti.jump = 1'b1;
        step(ti, 3);
        ti.id = 1'b1;
        step(ti, 3);
        ti = '0; ti.jump = 1'b1; ti.kill = 5'b00100;
        step(ti, 3);

        // 4: trap with fetch busy for two cycles
        ti = '0; ti.trap = 1'b1; ti.code = 4'h3; ti.ifu = 1'b1;
        step(ti, 4);
        ti = '0; ti.ifu = 1'b1; ti.trap = 1'b1; ti.code = 4'h7;
        step(ti, 4);
        idle(3, 4);

        // 5: hang after 1024 consecutive stalled cycles, sticky until reset
        do_reset(5);
        ti = '0; ti.exe = 1'b1;
        for (int k = 0; k < 1026; k++) step(ti, 5);
        idle(3, 5);
        do_reset(5);
        idle(1, 5);

        // 6: reset asserted while refilling
        ti = '0; ti.trap = 1'b1; ti.code = 4'h9; ti.ifu = 1'b1;
        step(ti, 6);
        ti = '0; ti.ifu = 1'b1;
        step(ti, 6);
        step(ti, 6);
        do_reset(6);
        idle(2, 6);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) do_reset(7);
            step(rand_in(), 7);
        end
        idle(2, 7);

        @(negedge clk);
        #1;
        check(8, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
